// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state encoding, fault codes and reset PC for the MIPS fetch unit
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic word_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - 8-bit request-cycle counter flagging the last cycle before a fetch timeout
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // High during the LIMIT-th request cycle, so the fault lands on that cycle's edge.
    assign expired = en && (count == LIMIT_M1);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and req/ack instruction fetch sequencer; PC_FETCH_PERF_EN adds perf counters
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [31:0] next_pc,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
);

    fetch_state_t state;
    logic         retire;
    logic         tmo_expired;

    assign retire    = (state == ST_ISSUE) && instr_ready && !stall;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    fetch_timeout_ctr #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clr     ((state != ST_FETCH) || imem_ack),
        .en      (state == ST_FETCH),
        .expired (tmo_expired)
    );

    // imem_req / instr_valid are registered alongside the next state so they always match it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= ST_ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (tmo_expired) begin
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                        state      <= ST_HALT;
                        imem_req   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
                        if (word_aligned(next_pc[1:0])) begin
                            pc       <= next_pc;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= FAULT_MISALIGN;
                            state      <= ST_HALT;
                        end
                    end
                end
                default: begin
                    state       <= ST_HALT;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_cycles  <= 32'd0;
            perf_retired <= 32'd0;
        end else begin
            if (state == ST_FETCH || state == ST_ISSUE) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (retire) begin
                perf_retired <= perf_retired + 32'd1;
            end
        end
    end
`else
    assign perf_cycles  = 32'd0;
    assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with MEM_TIMEOUT=4
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] perf_cycles;
    logic [31:0] perf_retired;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .fault        (fault),
        .fault_code   (fault_code),
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        model_pc = 32'h0;
        exp_q.delete();
    endtask

    // Ack the current request cycle and record the expected {pc, instr} for issue.
    task automatic drive_ack(input logic [31:0] data);
        imem_ack = 1'b1;
        imem_rdata = data;
        exp_q.push_back({model_pc, data});
        tick();
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic sb_pop(output logic [63:0] e, output bit ok);
        ok = (exp_q.size() != 0);
        e = ok ? exp_q.pop_front() : 64'h0;
    endtask

    task automatic do_retire(input logic [31:0] npc);
        instr_ready = 1'b1;
        next_pc = npc;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if ({fault, fault_code} !== 3'b000) begin errors++; $display("FAIL reset_fault: got %b want 000", {fault, fault_code}); end
    endtask

    task automatic test_first_fetch();
        logic [63:0] e;
        bit ok;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tick();
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req3: got %b want 1", imem_req); end
        drive_ack(32'h2008_0005);
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL first_issue: got valid=%b req=%b want 1/0", instr_valid, imem_req); end
        sb_pop(e, ok);
        checks++; if (!ok || {pc, instr} !== e) begin errors++; $display("FAIL first_sb: got %h_%h want %h", pc, instr, e); end
        checks++; if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL first_pc4: got %h want 4", pc_plus4); end
    endtask

    task automatic test_sequential_retire();
        logic [63:0] e;
        bit ok;
        tick();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL seq_hold: got req=%b valid=%b want 0/1", imem_req, instr_valid); end
        do_retire(32'd4);
        model_pc = 32'd4;
        checks++; if (pc !== 32'd4 || imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL seq_refetch: got pc=%h req=%b addr=%h want 4/1/4", pc, imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0 || pc_plus4 !== 32'd8) begin errors++; $display("FAIL seq_state: got valid=%b pc4=%h want 0/8", instr_valid, pc_plus4); end
        drive_ack(32'h0109_4820);
        sb_pop(e, ok);
        checks++; if (!ok || instr_valid !== 1'b1 || {pc, instr} !== e) begin errors++; $display("FAIL seq_sb: got %h_%h v=%b want %h", pc, instr, instr_valid, e); end
    endtask

    task automatic test_stall();
        logic [63:0] e;
        bit ok;
        stall = 1'b1;
        instr_ready = 1'b1;
        next_pc = 32'd8;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || pc !== 32'd4 || instr !== 32'h0109_4820 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h req=%b want 1/4/01094820/0", i, instr_valid, pc, instr, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        instr_ready = 1'b0;
        model_pc = 32'd8;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'd8) begin errors++; $display("FAIL stall_release: got v=%b req=%b pc=%h want 0/1/8", instr_valid, imem_req, pc); end
        tick();
        drive_ack(32'h8C43_0000);
        sb_pop(e, ok);
        checks++; if (!ok || {pc, instr} !== e) begin errors++; $display("FAIL stall_sb: got %h_%h want %h", pc, instr, e); end
    endtask

    task automatic test_misaligned();
        do_retire(32'h0000_0042);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin errors++; $display("FAIL mis_fault: got %b/%b want 1/01", fault, fault_code); end
        checks++; if (pc !== 32'd8 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_state: got pc=%h v=%b req=%b want 8/0/0", pc, instr_valid, imem_req); end
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault_code !== 2'b01 || instr !== 32'h8C43_0000) begin
                errors++; $display("FAIL mis_halt%0d: got req=%b v=%b code=%b instr=%h want 0/0/01/8c430000", i, imem_req, instr_valid, fault_code, instr);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) n++;
            if (fault === 1'b1) break;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL tmo_cycles: got %0d want 4", n); end
        checks++; if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0) begin errors++; $display("FAIL tmo_fault: got %b/%b req=%b want 1/10/0", fault, fault_code, imem_req); end
    endtask

    task automatic test_ack_at_limit();
        logic [63:0] e;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (imem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL lim_req4: got req=%b fault=%b want 1/0", imem_req, fault); end
        drive_ack(32'h2409_0007);
        sb_pop(e, ok);
        checks++; if (fault !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL lim_nofault: got fault=%b v=%b want 0/1", fault, instr_valid); end
        checks++; if (!ok || {pc, instr} !== e) begin errors++; $display("FAIL lim_sb: got %h_%h want %h", pc, instr, e); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [63:0] e;
        bit ok;
        do_retire(32'h0000_0100);
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mid_req: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        RST = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        RST = 1'b0;
        imem_ack = 1'b0;
        model_pc = 32'h0;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got req=%b v=%b pc=%h instr=%h want 0/0/0/0", imem_req, instr_valid, pc, instr);
        end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_fresh: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        drive_ack(32'h0000_000C);
        sb_pop(e, ok);
        checks++; if (!ok || {pc, instr} !== e) begin errors++; $display("FAIL mid_sb: got %h_%h want %h", pc, instr, e); end
    endtask

    task automatic test_pc_wrap();
        logic [63:0] e;
        bit ok;
        do_retire(32'hFFFF_FFFC);
        model_pc = 32'hFFFF_FFFC;
        checks++; if (pc_plus4 !== 32'h0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc4: got pc4=%h addr=%h want 0/fffffffc", pc_plus4, imem_addr); end
        drive_ack(32'h0800_0000);
        sb_pop(e, ok);
        checks++; if (!ok || {pc, instr} !== e) begin errors++; $display("FAIL wrap_sb: got %h_%h want %h", pc, instr, e); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
`ifndef PC_FETCH_PERF_EN
        checks++; if (perf_cycles !== 32'h0 || perf_retired !== 32'h0) begin errors++; $display("FAIL perf_tied: got %h/%h want 0/0", perf_cycles, perf_retired); end
`endif
    endtask

    initial begin
        RST = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        stall = 1'b0;
        next_pc = 32'h0;
        model_pc = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential_retire();
        test_stall();
        test_misaligned();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_fetch();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the single-cycle MIPS core.
- Sits directly upstream of the next-address mux:
  - Supplies the current PC and PC+4 to that mux.
  - Consumes its selected next address on instruction retire.
- Drives a req/ack instruction-memory port and presents one fetched instruction at a time to decode/execute.
- Flags misaligned PCs and memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before a fault; valid range 1..255.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high until acked.
- imem_addr  out  32  byte address of fetch; equals pc while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction for decode.
- instr_valid  out  1  instr is valid and awaiting retire.
- instr_ready  in  1  execute has completed the current instruction.
- stall  in  1  hold current instruction; blocks retire.
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc+4, feeds the next-address mux.
- next_pc  in  32  selected next address from the next-address mux.
- fault  out  1  sticky error, cleared only by RST.
- fault_code  out  2  00 none, 01 misaligned next_pc, 10 imem timeout.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- States: IDLE, FETCH, ISSUE, HALT. State is encoded in 2 bits; outputs are decoded from registered state (Moore).
- Reset values (RST high at an edge, from any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, instr=0, fault=0, fault_code=00, timeout counter=0.
  - Outputs: imem_req=0, instr_valid=0.
- An imem_ack arriving in the same cycle as RST is discarded.
- IDLE: next cycle -> FETCH, unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc; timeout counter increments each cycle.
  - imem_ack=1: instr<=imem_rdata, counter<=0, -> ISSUE.
    - Latency: one cycle from ack to instr_valid=1.
  - Counter reaches MEM_TIMEOUT with no ack: fault<=1, fault_code<=10, -> HALT.
  - Ack on the same edge as the counter reaching MEM_TIMEOUT: ack wins, no fault.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - Retire occurs when instr_ready=1 and stall=0.
  - On retire with next_pc[1:0]==00: pc<=next_pc, -> FETCH.
  - On retire with next_pc[1:0]!=00: pc unchanged, fault<=1, fault_code<=01, -> HALT.
  - stall=1 holds ISSUE indefinitely; instr and pc are stable.
- HALT: imem_req=0, instr_valid=0. Only RST exits this state.
- imem_ack while imem_req=0 is ignored.
- pc_plus4 = pc + 32'd4, combinational, modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0.
- imem_addr = pc in all states; only meaningful while imem_req=1.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined: adds two 32-bit output counters, both reset to 0 and wrapping at 2^32.
  - perf_cycles: increments every cycle that state != IDLE/HALT.
  - perf_retired: increments on each retire.
- Undefined: both ports remain present and are tied to 0; no counter registers are built.

Decomposition:
- Shared package (cpu_pkg) holds:
  - State encoding constants.
  - fault_code constants FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT.
  - Default RESET_PC.
- One natural sub-module: fetch_timeout_ctr.
  - 8-bit counter with clear and enable inputs and an expiry output.
  - Compared against MEM_TIMEOUT.
- Everything else stays in the top module.

Test Plan:
- Reset and first fetch:
  - Stimulus: RST high 2 cycles, release; imem_ack with imem_rdata=32'h2008_0005 on the 3rd cycle of imem_req.
  - Required: imem_addr=0; instr=32'h2008_0005 with instr_valid=1 one cycle after ack; pc_plus4=4.
- Sequential retire:
  - Stimulus: instr_ready=1, next_pc=4.
  - Required: pc=4, new imem_req; imem_req stays low during ISSUE.
- Stall:
  - Stimulus: stall=1 for 5 cycles with instr_ready=1.
  - Required: instr_valid remains 1, pc unchanged.
  - Release stall: retire on the next edge.
- Misaligned redirect:
  - Stimulus: retire with next_pc=32'h0000_0042.
  - Required: fault=1, fault_code=01, pc unchanged, instr_valid=0, no further imem_req.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, never ack.
  - Required: fault_code=10 after 4 request cycles.
  - Ack exactly on the 4th cycle instead: normal ISSUE, fault=0.
- Reset mid-fetch:
  - Stimulus: RST during FETCH, with imem_ack in the same cycle.
  - Required: ack dropped, pc=RESET_PC, IDLE, then a fresh request.
